board_streamer: RTL

- Downstream stage of the sudoku solver. Takes the solver's flat 324-bit board, snapshots it on `start_in` and streams it out one cell per beat over a valid/ready interface, with row/column tags.
- Feeds the display/UART formatter.
- Keeps a count of unsolved (zero) cells and flags illegal BCD digits, for status reporting.

---
 rtl/board_streamer.sv | 125 ++++++++++++
 1 files changed

// File: rtl/board_streamer.sv
// Snapshots a flat sudoku board on start and streams it one cell per
// valid/ready beat with row/column tags, zero-cell count and BCD error flag.
module board_streamer #(
  parameter int GRID_SIZE = 9,
  parameter int CELL_W    = 4
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic [CELL_W*GRID_SIZE*GRID_SIZE-1:0] board_in,
  input  logic                                  start_in,
  output logic                                  busy_out,
  output logic                                  cell_valid_out,
  input  logic                                  cell_ready_in,
  output logic [CELL_W-1:0]                     cell_value_out,
  output logic [3:0]                            cell_row_out,
  output logic [3:0]                            cell_col_out,
  output logic                                  cell_last_out,
  output logic                                  done_out,
  output logic [6:0]                            empty_count_out,
  output logic                                  error_out
);

  localparam int BW = CELL_W * GRID_SIZE * GRID_SIZE;
  localparam logic [3:0] MAXI = 4'(GRID_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [BW-1:0]     snap_q, snap_d;
  logic [3:0]        row_q, row_d;
  logic [3:0]        col_q, col_d;
  logic [6:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [CELL_W-1:0] cur;
  logic              at_last;
  logic              xfer;

  // The snapshot shifts left per transfer, so the head nibble is always
  // the current cell in row-major order.
  assign cur     = snap_q[BW-1 -: CELL_W];
  assign at_last = (row_q == MAXI) && (col_q == MAXI);
  assign xfer    = (state_q == STREAM) && cell_ready_in;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_in) begin
          snap_d  = board_in;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          snap_d = {snap_q[BW-CELL_W-1:0], {CELL_W{1'b0}}};
          if (cur == '0) begin
            cnt_d = cnt_q + 7'd1;
          end
          if (cur > CELL_W'(9)) begin
            err_d = 1'b1;
          end
          if (at_last) begin
            row_d   = '0;
            col_d   = '0;
            state_d = DONE;
          end else if (col_q == MAXI) begin
            col_d = '0;
            row_d = row_q + 4'd1;
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
      snap_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign cell_valid_out  = (state_q == STREAM);
  assign busy_out        = (state_q == STREAM);
  assign done_out        = (state_q == DONE);
  assign cell_value_out  = cur;
  assign cell_row_out    = row_q;
  assign cell_col_out    = col_q;
  assign cell_last_out   = cell_valid_out && at_last;
  assign empty_count_out = cnt_q;
  assign error_out       = err_q;

endmodule
